// File: rtl/execute_cycle_if.sv
// E-stage control/data inputs and E/M pipeline outputs of the execute stage.
// The slave side is the execute stage itself; the master side is the surrounding pipeline.
interface execute_cycle_if #(
   parameter int XLEN = 32
);
   logic            RegWriteE;
   logic            ALUSrcE;
   logic            MemWriteE;
   logic            JumpE;
   logic            BranchE;
   logic [1:0]      ResultSrcE;
   logic [2:0]      ALUControlE;
   logic [XLEN-1:0] RD1_E;
   logic [XLEN-1:0] RD2_E;
   logic [XLEN-1:0] Imm_Ext_E;
   logic [4:0]      RD_E;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic [XLEN-1:0] ResultW;
   logic            FlushM;

   logic            PCSrcE;
   logic [XLEN-1:0] PCTargetE;
   logic            RegWriteM;
   logic            MemWriteM;
   logic [1:0]      ResultSrcM;
   logic [4:0]      RD_M;
   logic [XLEN-1:0] ALUResultM;
   logic [XLEN-1:0] WriteDataM;
   logic [XLEN-1:0] PCPlus4M;

   modport slave (
      input  RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ForwardAE, ForwardBE,
             ResultW, FlushM,
      output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             ALUResultM, WriteDataM, PCPlus4M
   );

   modport master (
      output RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ForwardAE, ForwardBE,
             ResultW, FlushM,
      input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             ALUResultM, WriteDataM, PCPlus4M
   );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution and the E/M pipeline register.
// Branch target and redirect are combinational; everything heading to M is registered.
module execute_cycle #(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst,
   execute_cycle_if.slave   ex
);
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] rs2_fwd;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] diff;
   logic            zero;

   logic            reg_write_q,   reg_write_d;
   logic            mem_write_q,   mem_write_d;
   logic [1:0]      result_src_q,  result_src_d;
   logic [4:0]      rd_q,          rd_d;
   logic [XLEN-1:0] alu_result_q,  alu_result_d;
   logic [XLEN-1:0] write_data_q,  write_data_d;
   logic [XLEN-1:0] pc_plus4_q,    pc_plus4_d;

   // 10 forwards from this stage's own E/M register, i.e. the previous ALU result
   always_comb begin
      src_a = ex.RD1_E;
      case (ex.ForwardAE)
         2'b01:   src_a = ex.ResultW;
         2'b10:   src_a = alu_result_q;
         default: src_a = ex.RD1_E;
      endcase
      rs2_fwd = ex.RD2_E;
      case (ex.ForwardBE)
         2'b01:   rs2_fwd = ex.ResultW;
         2'b10:   rs2_fwd = alu_result_q;
         default: rs2_fwd = ex.RD2_E;
      endcase
      src_b = ex.ALUSrcE ? ex.Imm_Ext_E : rs2_fwd;
   end

   always_comb begin
      diff       = src_a - src_b;
      zero       = (diff == '0);
      alu_result = '0;
      case (ex.ALUControlE)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = diff;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_result = '0;
      endcase
   end

   assign ex.PCSrcE    = ex.JumpE | (ex.BranchE & zero);
   assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

   always_comb begin
      reg_write_d  = ex.RegWriteE;
      mem_write_d  = ex.MemWriteE;
      result_src_d = ex.ResultSrcE;
      rd_d         = ex.RD_E;
      alu_result_d = alu_result;
      write_data_d = rs2_fwd;
      pc_plus4_d   = ex.PCPlus4E;
      if (ex.FlushM) begin
         reg_write_d  = 1'b0;
         mem_write_d  = 1'b0;
         result_src_d = 2'b00;
         rd_d         = '0;
         alu_result_d = '0;
         write_data_d = '0;
         pc_plus4_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 2'b00;
         rd_q         <= '0;
         alu_result_q <= '0;
         write_data_q <= '0;
         pc_plus4_q   <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
      end
   end

   assign ex.RegWriteM  = reg_write_q;
   assign ex.MemWriteM  = mem_write_q;
   assign ex.ResultSrcM = result_src_q;
   assign ex.RD_M       = rd_q;
   assign ex.ALUResultM = alu_result_q;
   assign ex.WriteDataM = write_data_q;
   assign ex.PCPlus4M   = pc_plus4_q;
endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: reset, ALU ops, forwarding, branch redirect, flush, store data.
module tb_execute_cycle;
   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   execute_cycle_if #(.XLEN(32)) ex_if ();

   execute_cycle #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .ex  (ex_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_m_zero(input string tag);
      chk({tag, ".regwrite"},  {31'b0, ex_if.RegWriteM}, 32'h0);
      chk({tag, ".memwrite"},  {31'b0, ex_if.MemWriteM}, 32'h0);
      chk({tag, ".resultsrc"}, {30'b0, ex_if.ResultSrcM}, 32'h0);
      chk({tag, ".rd"},        {27'b0, ex_if.RD_M}, 32'h0);
      chk({tag, ".aluresult"}, ex_if.ALUResultM, 32'h0);
      chk({tag, ".writedata"}, ex_if.WriteDataM, 32'h0);
      chk({tag, ".pcplus4"},   ex_if.PCPlus4M, 32'h0);
   endtask

   task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      ex_if.ALUSrcE     = 1'b0;
      ex_if.ForwardAE   = 2'b00;
      ex_if.ForwardBE   = 2'b00;
      ex_if.RD1_E       = a;
      ex_if.RD2_E       = b;
      ex_if.ALUControlE = op;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst     = 1'b1;
      ex_if.RegWriteE   = 1'b0;
      ex_if.ALUSrcE     = 1'b0;
      ex_if.MemWriteE   = 1'b0;
      ex_if.JumpE       = 1'b0;
      ex_if.BranchE     = 1'b0;
      ex_if.ResultSrcE  = 2'b00;
      ex_if.ALUControlE = 3'b000;
      ex_if.RD1_E       = 32'h0;
      ex_if.RD2_E       = 32'h0;
      ex_if.Imm_Ext_E   = 32'h0;
      ex_if.RD_E        = 5'd0;
      ex_if.PCE         = 32'h0;
      ex_if.PCPlus4E    = 32'h0;
      ex_if.ForwardAE   = 2'b00;
      ex_if.ForwardBE   = 2'b00;
      ex_if.ResultW     = 32'h0;
      ex_if.FlushM      = 1'b0;

      // reset held across edges with non-zero inputs
      ex_if.RegWriteE = 1'b1;
      ex_if.PCPlus4E  = 32'h44;
      repeat (2) @(posedge clk);
      #1;
      chk_m_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // signed slt, plus pass-through of control fields
      alu_op(32'd5, 32'd7, 3'b101);
      ex_if.RegWriteE  = 1'b1;
      ex_if.MemWriteE  = 1'b0;
      ex_if.ResultSrcE = 2'b10;
      ex_if.RD_E       = 5'd17;
      ex_if.PCPlus4E   = 32'h0000_0104;
      step();
      chk("slt_5_7",   ex_if.ALUResultM, 32'h1);
      chk("regwrite",  {31'b0, ex_if.RegWriteM}, 32'h1);
      chk("resultsrc", {30'b0, ex_if.ResultSrcM}, 32'h2);
      chk("rd_m",      {27'b0, ex_if.RD_M}, 32'd17);
      chk("pcplus4",   ex_if.PCPlus4M, 32'h0000_0104);
      chk("wdata_rd2", ex_if.WriteDataM, 32'd7);

      alu_op(32'h8000_0000, 32'h1, 3'b001);
      step();
      chk("sub_wrap", ex_if.ALUResultM, 32'h7FFF_FFFF);

      alu_op(32'hFFFF_FFFF, 32'h1, 3'b101);
      step();
      chk("slt_signed_neg", ex_if.ALUResultM, 32'h1);

      alu_op(32'h1, 32'hFFFF_FFFF, 3'b101);
      step();
      chk("slt_signed_pos", ex_if.ALUResultM, 32'h0);

      alu_op(32'hFFFF_FFFF, 32'h2, 3'b000);
      step();
      chk("add_wrap", ex_if.ALUResultM, 32'h1);

      alu_op(32'h0000_F0F0, 32'h0000_FF00, 3'b010);
      step();
      chk("and", ex_if.ALUResultM, 32'h0000_F000);

      alu_op(32'h0000_F0F0, 32'h0000_FF00, 3'b011);
      step();
      chk("or", ex_if.ALUResultM, 32'h0000_FFF0);

      alu_op(32'h0000_F0F0, 32'h0000_FF00, 3'b111);
      step();
      chk("op_111", ex_if.ALUResultM, 32'h0);

      alu_op(32'h0000_F0F0, 32'h0000_FF00, 3'b100);
      step();
      chk("op_100", ex_if.ALUResultM, 32'h0);

      // forwarding: first park 0x10 in ALUResultM
      ex_if.ALUSrcE     = 1'b1;
      ex_if.ALUControlE = 3'b000;
      ex_if.ForwardAE   = 2'b00;
      ex_if.RD1_E       = 32'h10;
      ex_if.Imm_Ext_E   = 32'h0;
      step();
      chk("fwd_setup", ex_if.ALUResultM, 32'h10);
      ex_if.RD1_E     = 32'h1;
      ex_if.ResultW   = 32'h20;
      ex_if.Imm_Ext_E = 32'h4;
      ex_if.ForwardAE = 2'b10;
      step();
      chk("fwd_a_mem", ex_if.ALUResultM, 32'h14);
      ex_if.ForwardAE = 2'b01;
      step();
      chk("fwd_a_wb", ex_if.ALUResultM, 32'h24);
      ex_if.ForwardAE = 2'b11;
      step();
      chk("fwd_a_11", ex_if.ALUResultM, 32'h5);

      // branch resolution is combinational and unaffected by FlushM
      @(negedge clk);
      alu_op(32'd9, 32'd9, 3'b001);
      ex_if.BranchE   = 1'b1;
      ex_if.PCE       = 32'h100;
      ex_if.Imm_Ext_E = 32'hFFFF_FFF8;
      ex_if.FlushM    = 1'b1;
      #1;
      chk("beq_taken",  {31'b0, ex_if.PCSrcE}, 32'h1);
      chk("beq_target", ex_if.PCTargetE, 32'h0000_00F8);
      ex_if.RD2_E = 32'd8;
      #1;
      chk("beq_not_taken", {31'b0, ex_if.PCSrcE}, 32'h0);
      ex_if.JumpE = 1'b1;
      #1;
      chk("jump", {31'b0, ex_if.PCSrcE}, 32'h1);
      ex_if.JumpE   = 1'b0;
      ex_if.BranchE = 1'b0;
      ex_if.FlushM  = 1'b0;

      // flush overrides new data, then normal capture resumes
      alu_op(32'd3, 32'd4, 3'b000);
      ex_if.RegWriteE  = 1'b1;
      ex_if.MemWriteE  = 1'b1;
      ex_if.ResultSrcE = 2'b01;
      ex_if.RD_E       = 5'd9;
      ex_if.PCPlus4E   = 32'h200;
      ex_if.FlushM     = 1'b1;
      step();
      chk_m_zero("flush");
      ex_if.FlushM = 1'b0;
      step();
      chk("post_flush_mem", {31'b0, ex_if.MemWriteM}, 32'h1);
      chk("post_flush_reg", {31'b0, ex_if.RegWriteM}, 32'h1);
      chk("post_flush_alu", ex_if.ALUResultM, 32'd7);
      chk("post_flush_rd",  {27'b0, ex_if.RD_M}, 32'd9);

      // store data from writeback forward, immediate on B
      ex_if.ForwardBE = 2'b01;
      ex_if.ResultW   = 32'hDEAD_BEEF;
      ex_if.ALUSrcE   = 1'b1;
      ex_if.Imm_Ext_E = 32'h8;
      ex_if.RD1_E     = 32'h1000;
      ex_if.ForwardAE = 2'b00;
      ex_if.ALUControlE = 3'b000;
      step();
      chk("store_data", ex_if.WriteDataM, 32'hDEAD_BEEF);
      chk("store_addr", ex_if.ALUResultM, 32'h1008);
      ex_if.ForwardBE = 2'b10;
      ex_if.RD2_E     = 32'h5;
      step();
      chk("store_fwd_mem", ex_if.WriteDataM, 32'h1008);

      // asynchronous reset mid-cycle, away from any edge
      chk("pre_reset_regwrite", {31'b0, ex_if.RegWriteM}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk_m_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("after_reset_capture", ex_if.ALUResultM, 32'h1008);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port RegWriteE  in  1  register-file write enable of the E-stage instruction.
REQ-005 SHALL have port ALUSrcE  in  1  ALU operand B select: 0 = forwarded rs2, 1 = immediate.
REQ-006 SHALL have port MemWriteE  in  1  store enable.
REQ-007 SHALL have port JumpE  in  1  unconditional jump.
REQ-008 SHALL have port BranchE  in  1  conditional branch (beq).
REQ-009 SHALL have port ResultSrcE  in  2  writeback source select; passed through.
REQ-010 SHALL have port ALUControlE  in  3  ALU operation.
REQ-011 SHALL have port RD1_E  in  32  rs1 read data.
REQ-012 SHALL have port RD2_E  in  32  rs2 read data.
REQ-013 SHALL have port Imm_Ext_E  in  32  sign-extended immediate.
REQ-014 SHALL have port RD_E  in  5  destination register.
REQ-015 SHALL have port PCE  in  32  PC of the E-stage instruction.
REQ-016 SHALL have port PCPlus4E  in  32  PCE+4.
REQ-017 SHALL have port ForwardAE  in  2  operand A source: 00 RD1_E, 01 ResultW, 10 ALUResultM, 11 RD1_E.
REQ-018 SHALL have port ForwardBE  in  2  rs2 source, same encoding as ForwardAE, using RD2_E.
REQ-019 SHALL have port ResultW  in  32  writeback result, for forwarding.
REQ-020 SHALL have port FlushM  in  1  synchronous bubble insert into the E/M register.
REQ-021 SHALL have port PCSrcE  out  1  redirect fetch to PCTargetE (combinational).
REQ-022 SHALL have port PCTargetE  out  32  PCE + Imm_Ext_E, modulo 2^32 (combinational).
REQ-023 SHALL have port RegWriteM  out  1  registered RegWriteE.
REQ-024 SHALL have port MemWriteM  out  1  registered MemWriteE.
REQ-025 SHALL have port ResultSrcM  out  2  registered ResultSrcE.
REQ-026 SHALL have port RD_M  out  5  registered RD_E.
REQ-027 SHALL have port ALUResultM  out  32  registered ALU result.
REQ-028 SHALL have port WriteDataM  out  32  registered forwarded rs2 value (store data).
REQ-029 SHALL have port PCPlus4M  out  32  registered PCPlus4E.

Function
REQ-030 SHALL form SrcA from ForwardAE and the forwarded rs2 value from ForwardBE, with 10 selecting the module's own ALUResultM register.
REQ-031 SHALL take SrcB as Imm_Ext_E when ALUSrcE=1, otherwise as the forwarded rs2 value.
REQ-032 SHALL compute the ALU result for each ALUControlE code as follows: 000 add; 001 sub; 010 and; 011 or; 101 signed set-less-than (result 1 or 0); any other code gives 0. Add and sub wrap modulo 2^32.
REQ-033 SHALL drive ZeroE=1 when SrcA - SrcB == 0.
REQ-034 SHALL drive PCSrcE = JumpE | (BranchE & ZeroE), combinationally in the same cycle.
REQ-035 SHALL load every M output from its E-stage source on each rising clk edge, giving 1-cycle latency.
REQ-036 SHALL, when FlushM=1 at an edge, load RegWriteM=0, MemWriteM=0, ResultSrcM=00, RD_M=0 and clear all 32-bit M outputs to 0; FlushM overrides new data.
REQ-037 SHALL NOT let FlushM mask PCSrcE or PCTargetE in the same cycle.

Reset
REQ-038 SHALL, while rst=1 and independent of clk, drive every registered output to 0; the first capture is at the first rising edge after rst falls.

Verification
REQ-039 Reset: assert rst mid-run with RegWriteM=1 -> all M outputs are 0 immediately, without waiting for a clk edge.
REQ-040 ALU: RD1_E=5, RD2_E=7, ALUSrcE=0, ALUControlE=101 -> ALUResultM=1 after one edge; with RD1_E=0x80000000, RD2_E=1, ALUControlE=001 -> ALUResultM=0x7FFFFFFF.
REQ-041 Forwarding: ALUResultM=0x10, ResultW=0x20, RD1_E=0x1, ForwardAE=10, Imm_Ext_E=4, ALUSrcE=1, ALUControlE=000 -> ALUResultM=0x14; with ForwardAE=01 -> 0x24.
REQ-042 Branch: BranchE=1, equal operands, PCE=0x100, Imm_Ext_E=0xFFFFFFF8 -> PCSrcE=1 and PCTargetE=0xF8 in the same cycle; with unequal operands -> PCSrcE=0.
REQ-043 Flush: MemWriteE=1, RegWriteE=1, FlushM=1 -> after the edge MemWriteM=0 and RegWriteM=0; the next edge with FlushM=0 captures normally.
REQ-044 Store data: ForwardBE=01, ResultW=0xDEADBEEF, ALUSrcE=1 -> WriteDataM=0xDEADBEEF.
